// File: rtl/llr_accumulator.sv
// Saturating LLR accumulator: sums DEG signed messages per frame through a
// 6-bit ripple-carry slice and presents the frame sum on a valid/ready port.
module llr_accumulator #(
    parameter int DEG = 3,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_llr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_sat
);

    if (W != 6 || DEG < 2 || DEG > 15) begin : g_bad_param
        $error("llr_accumulator: W must be 6 and DEG must be in 2..15");
    end

    localparam logic [W-1:0] POS_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_EDGE = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] NEG_MAX  = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [3:0]   CNT_LAST = 4'(DEG - 1);

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state, state_next;
    logic [W-1:0] acc;
    logic [3:0]   cnt;
    logic         sat_flag;

    logic         accept;
    logic         last_accept;
    logic         release_res;

    logic [W-1:0] llr_clamped;
    logic [W-1:0] add_x, add_y, add_s;
    logic         add_cin;
    logic         add_cout_unused;
    logic         step_ovf;
    logic         step_sat;
    logic [W-1:0] step_sum;

    // -32 is folded onto -31 so the range stays symmetric
    assign llr_clamped = (in_llr == NEG_EDGE) ? NEG_MAX : in_llr;

    assign add_x   = acc;
    assign add_y   = llr_clamped;
    assign add_cin = 1'b0;

    // Ripple-carry slice (X/Y/C_in -> S/C_out)
    always_comb begin
        logic [W:0] carry;
        carry    = '0;
        carry[0] = add_cin;
        add_s    = '0;
        for (int unsigned i = 0; i < W; i++) begin
            add_s[i]     = add_x[i] ^ add_y[i] ^ carry[i];
            carry[i+1]   = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
        end
        add_cout_unused = carry[W];
    end

    // Signed overflow from sign bits; a non-overflowing -32 also saturates to -31
    assign step_ovf = (add_x[W-1] == add_y[W-1]) && (add_s[W-1] != add_x[W-1]);
    assign step_sat = step_ovf || (add_s == NEG_EDGE);

    always_comb begin
        step_sum = add_s;
        if (step_ovf) begin
            step_sum = add_x[W-1] ? NEG_MAX : POS_MAX;
        end else if (add_s == NEG_EDGE) begin
            step_sum = NEG_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        last_accept = 1'b0;
        release_res = 1'b0;
        case (state)
            ACC: begin
                accept = in_valid;
                if (in_valid && cnt == CNT_LAST) begin
                    last_accept = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_res = 1'b1;
                    state_next  = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            out_sum  <= '0;
            out_sat  <= 1'b0;
        end else if (release_res) begin
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
        end else if (accept) begin
            acc      <= step_sum;
            sat_flag <= sat_flag | step_sat;
            if (last_accept) begin
                out_sum <= step_sum;
                out_sat <= sat_flag | step_sat;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_llr_accumulator.sv
// Directed bench for llr_accumulator (DEG=3) with hand-computed expected values.
module tb_llr_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_llr;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sum;
    logic       out_sat;

    int n_checks;
    int n_fail;

    llr_accumulator #(.DEG(3), .W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_llr    (in_llr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_llr   = 6'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_fall"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_llr    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);

        // 1: basic sum 5 - 3 + 10 = 12
        send(5);
        send(-3);
        check("t1_ov_early", 32'(out_valid), 32'd0);
        send(10);
        check("t1_ov", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'd12);
        check("t1_sat", 32'(out_sat), 32'd0);
        check("t1_ir", 32'(in_ready), 32'd0);
        release_result("t1");

        // 2: 20 + 15 saturates to 31, then -10 gives 21
        send(20);
        send(15);
        check("t2_acc31", 32'(dut.acc), 32'h1f);
        send(-10);
        check("t2_sum", 32'(out_sum), 32'd21);
        check("t2_sat", 32'(out_sat), 32'd1);
        release_result("t2");

        // 3: -32 -> -31, -31 + -1 = -32 -> -31
        send(-32);
        send(-1);
        send(0);
        check("t3_sum", 32'(out_sum), 32'h21);
        check("t3_sat", 32'(out_sat), 32'd1);
        release_result("t3");

        // 4: backpressure with in_valid held and in_llr = 7
        send(1);
        send(2);
        send(3);
        check("t4_ov", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_llr   = 6'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_sum", 32'(out_sum), 32'd6);
            check("t4_hold_ov", 32'(out_valid), 32'd1);
            check("t4_hold_ir", 32'(in_ready), 32'd0);
        end
        check("t4_acc_stable", 32'(dut.acc), 32'd6);
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4_ov_fall", 32'(out_valid), 32'd0);
        check("t4_ir_back", 32'(in_ready), 32'd1);
        check("t4_acc_clear", 32'(dut.acc), 32'd0);

        // 5: reset mid-frame, with a competing valid input on the reset cycle
        send(9);
        send(9);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_llr   = 6'd9;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t5_acc_rst", 32'(dut.acc), 32'd0);
        check("t5_ir", 32'(in_ready), 32'd1);
        send(1);
        send(1);
        send(1);
        check("t5_ov", 32'(out_valid), 32'd1);
        check("t5_sum", 32'(out_sum), 32'd3);
        check("t5_sat", 32'(out_sat), 32'd0);
        release_result("t5");

        // 6: bubbles between messages
        send(2);
        tick();
        tick();
        check("t6_ov_gap1", 32'(out_valid), 32'd0);
        send(2);
        tick();
        tick();
        check("t6_ov_gap2", 32'(out_valid), 32'd0);
        check("t6_cnt", 32'(dut.cnt), 32'd2);
        send(2);
        check("t6_ov", 32'(out_valid), 32'd1);
        check("t6_sum", 32'(out_sum), 32'd6);
        release_result("t6");

        // Reset while holding a result drops it
        send(4);
        send(4);
        send(4);
        check("t7_sum", 32'(out_sum), 32'd12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_ov", 32'(out_valid), 32'd0);
        check("t7_sum_rst", 32'(out_sum), 32'd0);
        check("t7_ir", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
